// File: rtl/cacheline_xfer_ctrl.sv
// Memory-side line transfer sequencer: splits fill / writeback requests into word beats.
// Optional per-beat watchdog enabled by defining CACHELINE_XFER_CTRL_TIMEOUT_EN.
module cacheline_xfer_ctrl #(
  parameter int unsigned LINE_WIDTH     = 256,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_read,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [ADDR_WIDTH-1:0]   req_wb_addr,
  input  logic [LINE_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  output logic [LINE_WIDTH-1:0]   resp_rdata,
  output logic                    resp_err,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [WORD_WIDTH-1:0]   mem_wdata,
  output logic [WORD_WIDTH/8-1:0] mem_byte_enable,
  input  logic                    mem_resp,
  input  logic [WORD_WIDTH-1:0]   mem_rdata
);

  localparam int unsigned Beats  = LINE_WIDTH / WORD_WIDTH;
  localparam int unsigned BeatW  = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int unsigned ByteW  = WORD_WIDTH / 8;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'(LINE_WIDTH / 8 - 1);

  typedef enum logic [1:0] {StIdle, StWb, StFill, StDone} state_e;

  state_e                r_state, w_state_nxt;
  logic [BeatW-1:0]      r_beat, w_beat_nxt;
  logic [ADDR_WIDTH-1:0] r_fill_base, r_wb_base;
  logic [LINE_WIDTH-1:0] r_wdata, r_line, r_rdata, w_line_upd;
  logic                  r_read;
  logic                  w_timeout;
  logic [ADDR_WIDTH-1:0] w_offset;

`ifdef CACHELINE_XFER_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] r_tmo;
  logic            r_err;
  logic            w_busy;

  assign w_busy    = (r_state == StWb) || (r_state == StFill);
  assign w_timeout = w_busy && !mem_resp && (r_tmo == TmoW'(TIMEOUT_CYCLES - 1));
  assign resp_err  = (r_state == StDone) && r_err;

  // Counter restarts whenever a beat completes or the controller is not waiting on memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo <= '0;
      r_err <= 1'b0;
    end else begin
      r_tmo <= (w_busy && !mem_resp && !w_timeout) ? r_tmo + 1'b1 : '0;
      r_err <= w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign resp_err  = 1'b0;
`endif

  assign w_offset   = ADDR_WIDTH'(r_beat) * ADDR_WIDTH'(ByteW);
  assign resp_rdata = r_rdata;

  always_comb begin
    w_line_upd = r_line;
    w_line_upd[r_beat*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          if (req_write)     w_state_nxt = StWb;
          else if (req_read) w_state_nxt = StFill;
          else               w_state_nxt = StDone;
        end
      end
      StWb, StFill: begin
        if (w_timeout) begin
          w_state_nxt = StDone;
          w_beat_nxt  = '0;
        end else if (mem_resp) begin
          if (r_beat == LastBeat) begin
            w_beat_nxt  = '0;
            w_state_nxt = (r_state == StWb && r_read) ? StFill : StDone;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_comb begin
    req_ready       = (r_state == StIdle);
    resp_valid      = (r_state == StDone);
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    if (r_state == StWb) begin
      mem_write       = 1'b1;
      mem_address     = r_wb_base + w_offset;
      mem_wdata       = r_wdata[r_beat*WORD_WIDTH +: WORD_WIDTH];
      mem_byte_enable = '1;
    end else if (r_state == StFill) begin
      mem_read    = 1'b1;
      mem_address = r_fill_base + w_offset;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_beat      <= '0;
      r_fill_base <= '0;
      r_wb_base   <= '0;
      r_wdata     <= '0;
      r_read      <= 1'b0;
      r_line      <= '0;
      r_rdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      if (r_state == StIdle && req_valid) begin
        r_fill_base <= req_addr & ~OffMask;
        r_wb_base   <= req_wb_addr & ~OffMask;
        r_wdata     <= req_wdata;
        r_read      <= req_read;
      end
      // Words collect in r_line; only a completed fill is published to r_rdata.
      if (r_state == StFill && mem_resp) begin
        r_line <= w_line_upd;
        if (r_beat == LastBeat) r_rdata <= w_line_upd;
      end
    end
  end

endmodule

// File: tb/tb_cacheline_xfer_ctrl.sv
// Self-checking bench for cacheline_xfer_ctrl: vector table, random stalls, mid-fill reset.
module tb_cacheline_xfer_ctrl;

  localparam int LW    = 256;
  localparam int WW    = 32;
  localparam int AW    = 32;
  localparam int BEATS = LW / WW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_read = 1'b0, req_write = 1'b0;
  logic [AW-1:0] req_addr = '0, req_wb_addr = '0;
  logic [LW-1:0] req_wdata = '0;
  logic          resp_valid, resp_err;
  logic [LW-1:0] resp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;
  logic [WW-1:0] mem_wdata;
  logic [3:0]    mem_byte_enable;
  logic          mem_resp = 1'b0;
  logic [WW-1:0] mem_rdata = '0;

  cacheline_xfer_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_wb_addr     (req_wb_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_byte_enable (mem_byte_enable),
    .mem_resp        (mem_resp),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [LW-1:0] model_line = '0;

  typedef struct {
    bit            rd;
    bit            wr;
    logic [AW-1:0] addr;
    logic [AW-1:0] wb;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rline;
    logic [LW-1:0] exp_line;
  } vec_t;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*WW +: WW] = base + 32'(i);
    return l;
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] l;
    for (int i = 0; i < BEATS; i++) l[i*WW +: WW] = $urandom;
    return l;
  endfunction

  // One full transaction; abort_at > 0 asserts reset after that many completed beats.
  task automatic xfer(input bit rd, input bit wr, input logic [AW-1:0] addr,
                      input logic [AW-1:0] wb, input logic [LW-1:0] wdata,
                      input logic [LW-1:0] rline, input logic [LW-1:0] exp_line,
                      input int maxd, input int abort_at);
    int nb;
    logic [AW-1:0] base;
    logic [71:0] expv, actv;
    nb = 0;
    @(negedge clk);
    chk("idle_ready", LW'(req_ready), LW'(1));
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_addr = addr; req_wb_addr = wb; req_wdata = wdata;
    @(posedge clk); #1;
    // Request inputs are scrambled while busy; they must be ignored.
    req_read = 1'($urandom); req_write = 1'($urandom);
    req_addr = $urandom; req_wb_addr = $urandom; req_wdata = rnd_line();
    for (int ph = 0; ph < 2; ph++) begin
      if ((ph == 0 && wr) || (ph == 1 && rd)) begin
        base = (ph == 0) ? (wb & ~32'h1f) : (addr & ~32'h1f);
        for (int b = 0; b < BEATS; b++) begin
          int d;
          d = (maxd > 0) ? $urandom_range(0, maxd) : 0;
          expv = {1'b0, 1'b0, ph == 1, ph == 0, base + 32'(4 * b),
                  (ph == 0) ? wdata[b*WW +: WW] : 32'h0, (ph == 0) ? 4'hf : 4'h0};
          for (int k = 0; k <= d; k++) begin
            mem_resp  = (k == d);
            mem_rdata = (k == d) ? rline[b*WW +: WW] : $urandom;
            req_valid = 1'($urandom);
            @(negedge clk);
            actv = {req_ready, resp_valid, mem_read, mem_write, mem_address,
                    (ph == 0) ? mem_wdata : 32'h0, mem_byte_enable};
            chk(ph == 0 ? "wb_beat" : "fill_beat", LW'(actv), LW'(expv));
            @(posedge clk); #1;
          end
          mem_resp = 1'b0;
          nb++;
          if (nb == abort_at) begin
            req_valid = 1'b0;
            #2 rst = 1'b0;
            #1;
            chk("rst_async_outs", LW'({req_ready, resp_valid, mem_read, mem_write,
                                       mem_byte_enable}), LW'(8'b1000_0000));
            chk("rst_async_rdata", resp_rdata, '0);
            for (int c = 0; c < 2; c++) begin
              @(negedge clk);
              chk("rst_no_resp", LW'(resp_valid), LW'(0));
            end
            @(posedge clk); #1 rst = 1'b1;
            return;
          end
        end
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    chk("resp_valid", LW'({resp_valid, mem_read, mem_write, req_ready}), LW'(4'b1000));
    chk("resp_rdata", resp_rdata, exp_line);
    @(negedge clk);
    chk("resp_pulse", LW'({resp_valid, req_ready}), LW'(2'b01));
    chk("rdata_hold", resp_rdata, exp_line);
  endtask

  vec_t tbl[4];

  initial begin
    tbl[0] = '{rd: 1'b1, wr: 1'b0, addr: 32'h0000_1234, wb: 32'h0, wdata: '0,
               rline: mk_line(32'hA0),
               exp_line: 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};
    tbl[1] = '{rd: 1'b0, wr: 1'b1, addr: 32'h0, wb: 32'h0000_7F3C, wdata: mk_line(32'h5500),
               rline: '0,
               exp_line: 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};
    tbl[2] = '{rd: 1'b0, wr: 1'b0, addr: 32'h0000_0040, wb: 32'h0000_0080, wdata: '0,
               rline: '0,
               exp_line: 256'h000000A7_000000A6_000000A5_000000A4_000000A3_000000A2_000000A1_000000A0};
    tbl[3] = '{rd: 1'b1, wr: 1'b1, addr: 32'h0000_8040, wb: 32'h0000_4000,
               wdata: mk_line(32'h1000), rline: mk_line(32'hB0),
               exp_line: 256'h000000B7_000000B6_000000B5_000000B4_000000B3_000000B2_000000B1_000000B0};

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", LW'({req_ready, resp_valid, resp_err, mem_read, mem_write}), LW'(5'b10000));
    chk("reset_rdata", resp_rdata, '0);
    @(posedge clk); #1 rst = 1'b1;
    // mem_resp while idle is ignored
    mem_resp = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("idle_resp_ignored", LW'({req_ready, resp_valid, mem_read, mem_write}), LW'(4'b1000));
    mem_resp = 1'b0;

    for (int i = 0; i < 4; i++) begin
      xfer(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wb, tbl[i].wdata, tbl[i].rline,
           tbl[i].exp_line, 0, 0);
    end
    model_line = tbl[3].exp_line;

    // Reset mid-fill after beat 3, then a clean fill from beat 0
    xfer(1'b1, 1'b0, 32'h0000_2000, 32'h0, '0, mk_line(32'hC0), '0, 0, 4);
    model_line = '0;
    xfer(1'b1, 1'b0, 32'h0000_2010, 32'h0, '0, mk_line(32'hD0), mk_line(32'hD0), 0, 0);
    model_line = mk_line(32'hD0);

    // Random requests with stalling memory
    for (int i = 0; i < 24; i++) begin
      bit rd, wr;
      logic [LW-1:0] wdata, rline, exp;
      rd    = 1'($urandom);
      wr    = 1'($urandom);
      wdata = rnd_line();
      rline = rnd_line();
      exp   = rd ? rline : model_line;
      xfer(rd, wr, $urandom, $urandom, wdata, rline, exp, 5, 0);
      model_line = exp;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cacheline_xfer_ctrl.md
Name: cacheline_xfer_ctrl

Overview:
Sequences line transfers between the cache and 32-bit main memory, on the memory side of the cache-line serializer/deserializer.
- Accepts one line-level request (fill, writeback, or writeback-then-fill).
- Breaks each request into LINE_WIDTH/WORD_WIDTH word beats on the memory handshake.
- Assembles fill data into a full line and returns it to the cache with a one-cycle response pulse.

Parameters:
LINE_WIDTH, 256, cache line width in bits
WORD_WIDTH, 32, memory word width in bits; LINE_WIDTH must be a multiple of it
ADDR_WIDTH, 32, byte address width
TIMEOUT_CYCLES, 1024, watchdog limit per beat (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
req_valid  in  1  cache request valid
req_ready  out  1  controller can accept a request
req_read  in  1  fill line from req_addr
req_write  in  1  write back req_wdata to req_wb_addr
req_addr  in  ADDR_WIDTH  fill line address
req_wb_addr  in  ADDR_WIDTH  writeback line address
req_wdata  in  LINE_WIDTH  writeback line data
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  LINE_WIDTH  assembled fill line
resp_err  out  1  completion with error (optional feature only; tied 0 otherwise)
mem_read  out  1  word read command
mem_write  out  1  word write command
mem_address  out  ADDR_WIDTH  word byte address
mem_wdata  out  WORD_WIDTH  write word
mem_byte_enable  out  WORD_WIDTH/8  byte enables
mem_resp  in  1  memory beat complete
mem_rdata  in  WORD_WIDTH  read word, valid with mem_resp

Behaviour:
- BEATS = LINE_WIDTH/WORD_WIDTH (8 by default). Line offset bits are log2(LINE_WIDTH/8) (5 by default).
- Reset (rst=0, immediate, also mid-transfer): state IDLE, beat counter 0. All outputs 0 except req_ready=1. resp_rdata=0. No partial response is ever issued.
- States:
  - IDLE: req_ready=1. On req_valid && req_ready, latch addresses (offset bits forced 0), req_wdata, req_read, req_write.
    - req_write=1 -> WB.
    - else req_read=1 -> FILL.
    - both 0 -> DONE (no memory traffic).
  - WB:
    - mem_write=1.
    - mem_address = wb_base + beat*(WORD_WIDTH/8).
    - mem_wdata = wdata[beat*WORD_WIDTH +: WORD_WIDTH].
    - mem_byte_enable = all ones.
    - On mem_resp: if beat=BEATS-1, clear beat and go to FILL (if read latched) or DONE. Else increment beat.
  - FILL:
    - mem_read=1, mem_address = fill_base + beat*(WORD_WIDTH/8), mem_byte_enable=0.
    - On mem_resp: store mem_rdata into line slot beat (beat 0 -> bits [WORD_WIDTH-1:0], little-endian order). Last beat -> DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
    - resp_rdata updates only when a fill completes; it holds until the next fill completes.
- Commands are asserted continuously within a phase. Address and data change in the cycle after the mem_resp that completes the previous beat.
- mem_read and mem_write are never both 1.
- mem_resp in IDLE or DONE is ignored.
- A WB-to-FILL transition has no idle cycle.
- req_ready=0 in all non-IDLE states. Request inputs are ignored while busy.
- Latency with single-cycle mem_resp:
  - Fill: accept -> resp_valid = BEATS+1 cycles.
  - Writeback+fill: 2*BEATS+1 cycles.

Optional Feature:
Macro CACHELINE_XFER_CTRL_TIMEOUT_EN.
- Defined:
  - A per-beat counter resets on each beat start.
  - If it reaches TIMEOUT_CYCLES without mem_resp, commands drop and the FSM goes to DONE with resp_err=1 alongside resp_valid.
  - resp_rdata is not updated on an error completion.
- Undefined: no counter exists, resp_err is constant 0, and the controller waits indefinitely.

Test Plan:
- Reset then idle: rst low 3 cycles then high -> req_ready=1, mem_read=mem_write=0, resp_valid=0, resp_rdata=0.
- Fill: req_read, req_addr=0x0000_1234, memory returns word i = 0xA0+i with 1-cycle resp.
  - mem_address sequence 0x1220..0x123C.
  - resp_rdata = {0xA7,...,0xA0} (word-packed), resp_valid 9 cycles after accept.
- Writeback+fill: req_read=req_write=1, wb_addr=0x0000_4000, req_wdata word i = 0x1000+i.
  - 8 writes to 0x4000..0x401C with data 0x1000..0x1007 and byte enables 0xF.
  - Then 8 reads with no gap, one resp_valid pulse.
- Stalling memory: mem_resp delayed 0-5 random cycles per beat -> address and data held stable until each resp, correct line assembled.
- Reset mid-fill: rst asserted after beat 3 resp -> outputs clear immediately, no resp_valid. Next fill after release starts at beat 0.
- (TIMEOUT_EN, TIMEOUT_CYCLES=16) mem_resp never arrives on beat 2 -> mem_read drops, resp_valid=resp_err=1 in the same cycle, resp_rdata unchanged, req_ready=1 next cycle.
